// File: rtl/score_keeper.sv
// Score/lives bookkeeping: edge-detected hit/miss events drive a 4-digit BCD score,
// lives counter and game-over state. Optional high score via SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper #(
  parameter int unsigned HIT_PTS = 1,
  parameter int unsigned LIVES   = 3
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        game_rst,
  input  logic        hit,
  input  logic        miss,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        score_tick
);

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned PEND_W  = 2;
  localparam int unsigned LIVES_W = 2;

  localparam logic [STEP_W-1:0]  STEP_LOAD  = STEP_W'(HIT_PTS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 16'h9999;
  localparam logic [PEND_W-1:0]  PEND_MAX   = 2'd3;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_ADD  = 2'd1,
    S_OVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic                 tick_q, tick_d;
  logic                 game_over_q, game_over_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 rst_q, rst_d;
  logic                 hit_ev, miss_ev, rst_ev;
  logic [PEND_W-1:0]    pend_inc;

  // Single-point BCD increment; carry ripples through all four digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign hit_ev  = hit & ~hit_q;
  assign miss_ev = miss & ~miss_q;
  assign rst_ev  = game_rst & ~rst_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;
`endif

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    step_d   = step_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    pend_inc = pend_q;
    hit_d    = hit;
    miss_d   = miss;
    rst_d    = game_rst;

    if (rst_ev) begin
      state_d = S_PLAY;
      score_d = '0;
      lives_d = LIVES_INIT;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (lives_q == '0) begin
            state_d = S_OVER;
          end else begin
            if (miss_ev) lives_d = lives_q - 2'd1;
            if (hit_ev) begin
              state_d = S_ADD;
              step_d  = STEP_LOAD;
            end
          end
        end
        S_ADD: begin
          // A hit arriving on the final step is queued before the reload decision.
          if (hit_ev && (pend_q != PEND_MAX)) pend_inc = pend_q + 2'd1;
          pend_d = pend_inc;
          if (miss_ev && (lives_q != '0)) lives_d = lives_q - 2'd1;
          if (score_q != SCORE_MAX) score_d = bcd_inc(score_q);
          step_d = step_q - 4'd1;
          if (step_q == 4'd1) begin
            tick_d = 1'b1;
            if (lives_d == '0) begin
              state_d = S_OVER;
              pend_d  = '0;
            end else if (pend_inc != '0) begin
              pend_d = pend_inc - 2'd1;
              step_d = STEP_LOAD;
            end else begin
              state_d = S_PLAY;
            end
          end
        end
        S_OVER: ;
        default: state_d = S_PLAY;
      endcase
    end

    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_PLAY;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      step_q      <= '0;
      pend_q      <= '0;
      tick_q      <= 1'b0;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rst_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      rst_q       <= rst_d;
    end
  end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  // Capture the final score on the cycle the game ends.
  always_comb begin
    high_d = high_q;
    if ((state_q != S_OVER) && (state_d == S_OVER) && (score_d > high_q)) high_d = score_d;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) high_q <= '0;
    else        high_q <= high_d;
  end

  assign high_bcd = high_q;
`else
  assign high_bcd = 16'h0000;
`endif

  assign score_bcd  = score_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;
  assign score_tick = tick_q;

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against an integer game model.
module tb_score_keeper;

  localparam int HIT_PTS = 3;
  localparam int LIVES   = 3;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b0;
  logic        game_rst   = 1'b0;
  logic        hit        = 1'b0;
  logic        miss       = 1'b0;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic [1:0]  lives;
  logic        game_over;
  logic        score_tick;

  int total = 0;
  int bad   = 0;
  int ticks = 0;

  // Model state: plain integers, mode 0=play 1=adding 2=over.
  int m_score = 0, m_lives = LIVES, m_pend = 0, m_steps = 0, m_mode = 0, m_tick = 0, m_high = 0;
  bit ph = 0, pm = 0, pg = 0;

  score_keeper #(.HIT_PTS(HIT_PTS), .LIVES(LIVES)) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .game_rst  (game_rst),
    .hit       (hit),
    .miss      (miss),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .lives     (lives),
    .game_over (game_over),
    .score_tick(score_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic int exp_high();
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    return m_high;
`else
    return 0;
`endif
  endfunction

  task automatic end_game();
    m_mode = 2;
    m_pend = 0;
    if (m_score > m_high) m_high = m_score;
  endtask

  always @(posedge clk_100MHz) begin
    bit he, me, ge;
    if (!reset) begin
      m_score = 0; m_lives = LIVES; m_pend = 0; m_steps = 0; m_mode = 0; m_tick = 0; m_high = 0;
      ph = 0; pm = 0; pg = 0;
    end else begin
      he = hit & !ph; me = miss & !pm; ge = game_rst & !pg;
      m_tick = 0;
      if (ge) begin
        m_score = 0; m_lives = LIVES; m_pend = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (m_lives == 0) end_game();
        else begin
          if (me) m_lives--;
          if (he) begin m_mode = 1; m_steps = HIT_PTS; end
        end
      end else if (m_mode == 1) begin
        if (he && m_pend < 3) m_pend++;
        if (me && m_lives > 0) m_lives--;
        if (m_score < 9999) m_score++;
        m_steps--;
        if (m_steps == 0) begin
          m_tick = 1;
          if (m_lives == 0) end_game();
          else if (m_pend > 0) begin m_pend--; m_steps = HIT_PTS; end
          else m_mode = 0;
        end
      end
      ph = hit; pm = miss; pg = game_rst;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    check_eq("lives", 32'(lives), 32'(m_lives));
    check_eq("game_over", 32'(game_over), 32'(m_mode == 2));
    check_eq("tick", 32'(score_tick), 32'(m_tick));
    check_eq("high", 32'(high_bcd), 32'(to_bcd(exp_high())));
    if (score_tick) ticks++;
  endtask

  task automatic drive(input logic h, input logic m, input logic g);
    @(negedge clk_100MHz);
    check_all();
    hit = h; miss = m; game_rst = g;
  endtask

  task automatic check_reset_consts(input string tag);
    check_eq({tag, "_score"}, 32'(score_bcd), 32'h0);
    check_eq({tag, "_high"}, 32'(high_bcd), 32'h0);
    check_eq({tag, "_lives"}, 32'(lives), 32'(LIVES));
    check_eq({tag, "_over"}, 32'(game_over), 32'h0);
    check_eq({tag, "_tick"}, 32'(score_tick), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk_100MHz);
    check_reset_consts("rst");
    reset = 1'b1;

    // One long hit level counts once.
    ticks = 0;
    for (int i = 0; i < 50; i++) drive(1, 0, 0);
    drive(0, 0, 0);
    check_eq("held_hit_score", 32'(score_bcd), 32'(to_bcd(HIT_PTS)));
    check_eq("held_hit_ticks", 32'(ticks), 32'd1);
    check_eq("held_hit_lives", 32'(lives), 32'(LIVES));

    // Dense hit edges: buffering and pending saturation.
    for (int i = 0; i < 6; i++) begin drive(1, 0, 0); drive(0, 0, 0); end
    repeat (30) drive(0, 0, 0);

    // Random play including misses and restarts.
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    drive(0, 0, 1);
    drive(0, 0, 0);

    // Drive the score to saturation; ticks keep pulsing at 9999.
    for (int i = 0; i < 3400; i++) begin
      drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    end
    check_eq("sat_score", 32'(score_bcd), 32'h9999);

    // Lose all lives.
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0); drive(0, 0, 0); end
    repeat (3) drive(0, 0, 0);
    check_eq("over_flag", 32'(game_over), 32'h1);
    check_eq("over_lives", 32'(lives), 32'h0);
    drive(1, 0, 0);
    repeat (5) drive(0, 0, 0);
    check_eq("over_frozen", 32'(score_bcd), 32'h9999);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    check_eq("over_high", 32'(high_bcd), 32'h9999);
`endif

    // Restart wins over a same-cycle hit; high score kept.
    drive(1, 0, 1);
    drive(0, 0, 0);
    check_eq("restart_score", 32'(score_bcd), 32'h0);
    check_eq("restart_lives", 32'(lives), 32'(LIVES));
    check_eq("restart_over", 32'(game_over), 32'h0);
    check_eq("restart_tick", 32'(score_tick), 32'h0);
    check_eq("restart_high", 32'(high_bcd), 32'(to_bcd(exp_high())));

    // Asynchronous reset in the middle of an add sequence.
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check_eq("midadd_score", 32'(score_bcd), 32'h1);
    #2 reset = 1'b0;
    #1 check_reset_consts("async_rst");
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(negedge clk_100MHz);
    reset = 1'b1;
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game score and lives bookkeeping stage sitting directly downstream of the pixel generator. Consumes its `hit`/`miss` event levels, maintains a 4-digit packed-BCD score, remaining lives and an optional high score, and feeds the BCD score straight into the seven-segment display controller. Hits arriving while a multi-point increment is in progress are buffered, not lost.

## Interface

- `HIT_PTS`, default 1: points added per hit (1..15); applied as HIT_PTS single-point BCD increments.
- `LIVES`, default 3: lives at reset/restart (1..3).
- `clk_100MHz` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset), single clock domain.
- `game_rst` input 1: debounced restart level, synchronous; rising edge restarts game.
- `hit` input 1: ball-paddle contact level from pixel generator; may stay high many cycles.
- `miss` input 1: ball-lost level from pixel generator; may stay high many cycles.
- `score_bcd` output 16: packed BCD score, [15:12] thousands … [3:0] units.
- `high_bcd` output 16: packed BCD high score.
- `lives` output 2: remaining lives.
- `game_over` output 1: high while in OVER.
- `score_tick` output 1: one-cycle pulse when a hit's last point lands.

## Operation

- Edge detect: registered copies `hit_q`, `miss_q`, `rst_q`; event = input & ~registered copy. All edge registers reset to 0.
- FSM states: PLAY, ADD, OVER. Reset → PLAY.
- PLAY: hit edge → ADD with step counter = HIT_PTS.
- ADD: each cycle score += 1 (BCD, digit carry 9→0 ripples within the cycle), step counter −1; on last step pulse `score_tick`. Then:
  - if lives == 0 → OVER, pending cleared;
  - else if pending > 0 → pending −1, stay in ADD, counter reloaded (no PLAY gap);
  - else → PLAY.
- Pending: 2-bit counter; hit edge while in ADD → +1, saturates at 3 (further hits dropped).
- Saturation: score at 9999 holds; increments still consume cycles and `score_tick` still pulses.
- Miss edge: in PLAY or ADD, lives −1 (never below 0). In PLAY, lives reaching 0 → OVER next cycle. In ADD, current hit completes, then OVER.
- Simultaneous hit and miss edges in PLAY: hit counted (ADD entered), life lost, OVER after ADD if lives hit 0.
- OVER: hit/miss ignored, score frozen, `game_over` = 1.
- `game_rst` edge, any state: score = 0, lives = LIVES, pending = 0, FSM → PLAY, `score_tick` = 0; has priority over same-cycle hit/miss, which are discarded. High score is retained.
- Reset values: `score_bcd` 0, `high_bcd` 0, `lives` LIVES, `game_over` 0, `score_tick` 0, pending 0.

## Timing

- Hit edge sampled at edge k (PLAY): first increment visible after edge k+1; the last increment and the `score_tick` pulse are visible after edge k+HIT_PTS.
- Back-to-back buffered hits: continuous increments, HIT_PTS cycles per hit, no idle cycle.
- Miss edge at edge k: `lives` updated after edge k. `game_over` rises one cycle later from PLAY, or one cycle after the final ADD step.
- All outputs are registered; no combinational input-to-output path.
- Asynchronous reset assert: all state cleared immediately, including mid-ADD; deassert is synchronous to `clk_100MHz` via the top-level synchronizer.

## Configuration

- `SCORE_KEEPER_HIGH_SCORE_EN` defined: high-score register is present. On the cycle OVER is entered, if `score_bcd` > `high_bcd` (unsigned compare of packed BCD is valid), `high_bcd` ← `score_bcd`.
- Not defined: no high-score register; `high_bcd` is tied to 16'h0000.

## Test plan

- Reset, HIT_PTS=1: hit held high 50 cycles → score 0001, exactly one `score_tick`, lives 3.
- HIT_PTS=5: four hit edges 1 cycle apart → 3 buffered; score 0020 after 20 consecutive increment cycles, 4 ticks; a fifth edge during ADD with pending=3 is dropped.
- Preload 9998 via 9998 hits → one hit → 9999; next hit → still 9999, tick pulses.
- Three miss edges → lives 3,2,1,0; `game_over` 1; later hit → score unchanged; high score (macro on) = final score.
- `game_rst` edge in OVER with a simultaneous hit → score 0000, lives 3, PLAY, no tick; `high_bcd` retained.
- Reset asserted mid-ADD (HIT_PTS=8, 3 steps done) → all outputs return to reset values asynchronously.
